// File: rtl/axil_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master command port among NUM_REQ sources.
// Optional macro ARB_TIMEOUT_EN adds a done-wait timeout of TIMEOUT_CYCLES cycles.
module axil_cmd_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NUM_REQ-1:0]    req_wr_valid,
  output logic [NUM_REQ-1:0]    req_wr_ready,
  input  logic [NUM_REQ*32-1:0] req_wr_addr,
  input  logic [NUM_REQ*32-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]    req_wr_done,
  input  logic [NUM_REQ-1:0]    req_rd_valid,
  output logic [NUM_REQ-1:0]    req_rd_ready,
  input  logic [NUM_REQ*32-1:0] req_rd_addr,
  output logic [NUM_REQ-1:0]    req_rd_done,
  output logic [31:0]           req_rd_data,
  output logic [1:0]            req_error,
  output logic                  m_wr_valid,
  input  logic                  m_wr_ready,
  output logic [31:0]           m_wr_addr,
  output logic [31:0]           m_wr_data,
  input  logic                  m_wr_done,
  input  logic [1:0]            m_wr_error,
  output logic                  m_rd_valid,
  input  logic                  m_rd_ready,
  output logic [31:0]           m_rd_addr,
  input  logic [31:0]           m_rd_data,
  input  logic                  m_rd_done,
  input  logic [1:0]            m_rd_error
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("axil_cmd_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [IDW-1:0]   rr;
  logic [IDW-1:0]   grant;
  logic             op_wr;
  logic [NUM_REQ-1:0] pending;
  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   next_rr;

`ifdef ARB_TIMEOUT_EN
  logic [15:0]      tcnt;
`endif

  assign pending = req_wr_valid | req_rd_valid;
  assign next_rr = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  // First pending requester at or after rr, searching upward with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((32'(rr) + k) % 32'(NUM_REQ));
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      rr           <= '0;
      grant        <= '0;
      op_wr        <= 1'b0;
      req_wr_ready <= '0;
      req_rd_ready <= '0;
      req_wr_done  <= '0;
      req_rd_done  <= '0;
      req_rd_data  <= '0;
      req_error    <= '0;
      m_wr_valid   <= 1'b0;
      m_wr_addr    <= '0;
      m_wr_data    <= '0;
      m_rd_valid   <= 1'b0;
      m_rd_addr    <= '0;
`ifdef ARB_TIMEOUT_EN
      tcnt         <= '0;
`endif
    end else begin
      req_wr_ready <= '0;
      req_rd_ready <= '0;
      req_wr_done  <= '0;
      req_rd_done  <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant <= win;
            op_wr <= req_wr_valid[win];
            if (req_wr_valid[win]) begin
              req_wr_ready[win] <= 1'b1;
              m_wr_valid        <= 1'b1;
              m_wr_addr         <= req_wr_addr[32*win +: 32];
              m_wr_data         <= req_wr_data[32*win +: 32];
            end else begin
              req_rd_ready[win] <= 1'b1;
              m_rd_valid        <= 1'b1;
              m_rd_addr         <= req_rd_addr[32*win +: 32];
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if ((op_wr && m_wr_ready) || (!op_wr && m_rd_ready)) begin
            m_wr_valid <= 1'b0;
            m_rd_valid <= 1'b0;
            state      <= WAIT;
`ifdef ARB_TIMEOUT_EN
            tcnt       <= '0;
`endif
          end
        end
        WAIT: begin
          if (op_wr && m_wr_done) begin
            req_error          <= m_wr_error;
            req_wr_done[grant] <= 1'b1;
            rr                 <= next_rr;
            state              <= IDLE;
          end else if (!op_wr && m_rd_done) begin
            req_error          <= m_rd_error;
            req_rd_data        <= m_rd_data;
            req_rd_done[grant] <= 1'b1;
            rr                 <= next_rr;
            state              <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
            req_error   <= 2'b11;
            req_rd_data <= '0;
            if (op_wr) req_wr_done[grant] <= 1'b1;
            else       req_rd_done[grant] <= 1'b1;
            rr          <= next_rr;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_arbiter.sv
// Directed table-driven bench for axil_cmd_arbiter with two requesters.
module tb_axil_cmd_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [1:0]  req_wr_valid, req_wr_ready, req_wr_done;
  logic [63:0] req_wr_addr, req_wr_data;
  logic [1:0]  req_rd_valid, req_rd_ready, req_rd_done;
  logic [63:0] req_rd_addr;
  logic [31:0] req_rd_data;
  logic [1:0]  req_error;
  logic        m_wr_valid, m_wr_ready, m_wr_done;
  logic [31:0] m_wr_addr, m_wr_data;
  logic [1:0]  m_wr_error;
  logic        m_rd_valid, m_rd_ready, m_rd_done;
  logic [31:0] m_rd_addr, m_rd_data;
  logic [1:0]  m_rd_error;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axil_cmd_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .areset(areset),
    .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
    .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data), .req_wr_done(req_wr_done),
    .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
    .req_rd_addr(req_rd_addr), .req_rd_done(req_rd_done),
    .req_rd_data(req_rd_data), .req_error(req_error),
    .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready), .m_wr_addr(m_wr_addr),
    .m_wr_data(m_wr_data), .m_wr_done(m_wr_done), .m_wr_error(m_wr_error),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_addr(m_rd_addr),
    .m_rd_data(m_rd_data), .m_rd_done(m_rd_done), .m_rd_error(m_rd_error)
  );

  typedef struct {
    logic [1:0]  wv;
    logic [1:0]  rv;
    logic [63:0] wa;
    logic [63:0] wd;
    logic [63:0] ra;
    int          dly;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          g;
    bit          wr;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [12];
  vec_t tail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, {req_wr_ready, req_rd_ready}, 0);
    chk({tag, "_done"}, {req_wr_done, req_rd_done}, 0);
    chk({tag, "_rsp"}, {req_rd_data, req_error}, 0);
    chk({tag, "_mvalid"}, {m_wr_valid, m_rd_valid}, 0);
    chk({tag, "_maddr"}, {m_wr_addr, m_rd_addr}, 0);
    chk({tag, "_mwdata"}, m_wr_data, 0);
  endtask

  // One transaction: drive requests, follow the grant through ISSUE and WAIT.
  task automatic do_txn(input vec_t v);
    int n;
    logic [1:0] ev;
    req_wr_valid = v.wv; req_rd_valid = v.rv;
    req_wr_addr  = v.wa; req_wr_data  = v.wd; req_rd_addr = v.ra;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!(m_wr_valid || m_rd_valid) && n < 50);
    if (!(m_wr_valid || m_rd_valid)) begin
      chk("grant_wait", 0, 1);
      return;
    end
    ev = 2'(1 << v.g);
    chk("wr_ready", req_wr_ready, v.wr ? ev : 2'b00);
    chk("rd_ready", req_rd_ready, v.wr ? 2'b00 : ev);
    chk("m_valid", {m_wr_valid, m_rd_valid}, v.wr ? 2'b10 : 2'b01);
    chk("m_addr", v.wr ? m_wr_addr : m_rd_addr, v.ea);
    if (v.wr) chk("m_wr_data", m_wr_data, v.ed);
    if (v.wr) req_wr_valid[v.g] = 1'b0;
    else      req_rd_valid[v.g] = 1'b0;
    for (int i = 0; i < v.dly; i++) begin
      @(negedge aclk);
      chk("hold_no_ready", {req_wr_ready, req_rd_ready}, 0);
      chk("hold_valid", {m_wr_valid, m_rd_valid}, v.wr ? 2'b10 : 2'b01);
      chk("hold_addr", v.wr ? m_wr_addr : m_rd_addr, v.ea);
    end
    if (v.wr) m_wr_ready = 1'b1;
    else      m_rd_ready = 1'b1;
    @(negedge aclk);
    m_wr_ready = 1'b0; m_rd_ready = 1'b0;
    chk("valid_drop", {m_wr_valid, m_rd_valid}, 0);
    chk("ready_single", {req_wr_ready, req_rd_ready}, 0);
    // done for the other op type must not complete the transaction
    if (v.wr) begin m_rd_done = 1'b1; m_rd_error = 2'b11; m_rd_data = 32'hFFFF_FFFF; end
    else      begin m_wr_done = 1'b1; m_wr_error = 2'b11; end
    @(negedge aclk);
    m_rd_done = 1'b0; m_wr_done = 1'b0;
    chk("foreign_done", {req_wr_done, req_rd_done}, 0);
    if (v.wr) begin m_wr_done = 1'b1; m_wr_error = v.err; end
    else      begin m_rd_done = 1'b1; m_rd_error = v.err; m_rd_data = v.rdata; end
    @(negedge aclk);
    m_rd_done = 1'b0; m_wr_done = 1'b0;
    chk("wr_done", req_wr_done, v.wr ? ev : 2'b00);
    chk("rd_done", req_rd_done, v.wr ? 2'b00 : ev);
    chk("req_error", req_error, v.err);
    if (!v.wr) chk("req_rd_data", req_rd_data, v.rdata);
  endtask

  initial begin
    areset = 1'b1;
    req_wr_valid = '0; req_rd_valid = '0;
    req_wr_addr = '0; req_wr_data = '0; req_rd_addr = '0;
    m_wr_ready = 1'b0; m_wr_done = 1'b0; m_wr_error = '0;
    m_rd_ready = 1'b0; m_rd_done = 1'b0; m_rd_error = '0; m_rd_data = '0;

    //         wv     rv     wa                            wd                            ra                        dly rdata         err   g wr ea            ed
    tbl[0]  = '{2'b01, 2'b00, {32'h0, 32'h1000_0004}, {32'h0, 32'hDEAD_BEEF}, 64'h0,                    2, 32'h0,        2'b00, 0, 1, 32'h1000_0004, 32'hDEAD_BEEF};
    tbl[1]  = '{2'b00, 2'b10, 64'h0,                  64'h0,                  {32'h20, 32'h0},          0, 32'h1234_5678, 2'b10, 1, 0, 32'h20,        32'h0};
    tbl[2]  = '{2'b00, 2'b11, 64'h0,                  64'h0,                  {32'h200, 32'h100},       1, 32'hA0A0_0001, 2'b00, 0, 0, 32'h100,       32'h0};
    tbl[3]  = '{2'b00, 2'b11, 64'h0,                  64'h0,                  {32'h200, 32'h100},       1, 32'hB1B1_0002, 2'b01, 1, 0, 32'h200,       32'h0};
    tbl[4]  = '{2'b00, 2'b11, 64'h0,                  64'h0,                  {32'h200, 32'h100},       0, 32'hC2C2_0003, 2'b00, 0, 0, 32'h100,       32'h0};
    tbl[5]  = '{2'b00, 2'b11, 64'h0,                  64'h0,                  {32'h200, 32'h100},       3, 32'hD3D3_0004, 2'b11, 1, 0, 32'h200,       32'h0};
    tbl[6]  = '{2'b01, 2'b01, {32'h0, 32'h300},       {32'h0, 32'hAAAA_5555}, {32'h0, 32'h304},         0, 32'h0,        2'b00, 0, 1, 32'h300,       32'hAAAA_5555};
    tbl[7]  = '{2'b00, 2'b01, 64'h0,                  64'h0,                  {32'h0, 32'h304},         0, 32'h5A5A_5A5A, 2'b01, 0, 0, 32'h304,       32'h0};
    tbl[8]  = '{2'b11, 2'b00, {32'h400, 32'h500},     {32'h1111_1111, 32'h2222_2222}, 64'h0,            1, 32'h0,        2'b10, 1, 1, 32'h400,       32'h1111_1111};
    tbl[9]  = '{2'b01, 2'b00, {32'h400, 32'h500},     {32'h1111_1111, 32'h2222_2222}, 64'h0,            0, 32'h0,        2'b00, 0, 1, 32'h500,       32'h2222_2222};
    tbl[10] = '{2'b10, 2'b01, {32'h600, 32'h0},       {32'h3333_3333, 32'h0}, {32'h0, 32'h700},         0, 32'h0,        2'b00, 1, 1, 32'h600,       32'h3333_3333};
    tbl[11] = '{2'b00, 2'b01, 64'h0,                  64'h0,                  {32'h0, 32'h700},         2, 32'h7654_3210, 2'b00, 0, 0, 32'h700,       32'h0};
    tail    = '{2'b00, 2'b11, 64'h0,                  64'h0,                  {32'h900, 32'h800},       0, 32'hCAFE_F00D, 2'b01, 0, 0, 32'h800,       32'h0};

    repeat (3) @(negedge aclk);
    chk_quiet("reset");
    areset = 1'b0;

    for (int i = 0; i < 12; i++) do_txn(tbl[i]);

    // Reset while waiting for done: op dropped, late done ignored.
    req_wr_valid = 2'b01; req_wr_addr = {32'h0, 32'hBAD0_0000}; req_wr_data = {32'h0, 32'h0BAD_0BAD};
    begin
      int n;
      n = 0;
      do begin
        @(negedge aclk);
        n++;
      end while (!m_wr_valid && n < 50);
      chk("rst_seq_grant", {m_wr_valid, req_wr_ready}, 3'b101);
    end
    req_wr_valid = '0;
    m_wr_ready = 1'b1;
    @(negedge aclk);
    m_wr_ready = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk_quiet("midreset");
    m_wr_done = 1'b1; m_wr_error = 2'b01;
    @(negedge aclk);
    m_wr_done = 1'b0;
    chk("late_done", {req_wr_done, req_rd_done}, 0);
    @(negedge aclk);
    chk("late_done_idle", {req_wr_done, req_rd_done, m_wr_valid, m_rd_valid}, 0);

    // rr is back to 0, so requester 0 wins the tie
    do_txn(tail);

`ifdef ARB_TIMEOUT_EN
    req_rd_valid = 2'b11; req_rd_addr = {32'h900, 32'h800};
    begin
      int n;
      n = 0;
      do begin
        @(negedge aclk);
        n++;
      end while (!m_rd_valid && n < 50);
      chk("to_grant", req_rd_ready, 2'b10);
      req_rd_valid[1] = 1'b0;
      m_rd_ready = 1'b1;
      @(negedge aclk);
      m_rd_ready = 1'b0;
      n = 0;
      do begin
        @(negedge aclk);
        n++;
      end while (!(req_rd_done[1]) && n < 40);
      chk("to_cycles", n, 16);
      chk("to_done", req_rd_done, 2'b10);
      chk("to_rsp", {req_rd_data, req_error}, 34'h3);
    end
    tail.rv = 2'b01;
    tail.rdata = 32'h0101_0101;
    tail.err = 2'b00;
    do_txn(tail);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
